// File: rtl/dec_nto2n_seq_if.sv
// rtl/dec_nto2n_seq_if.sv - request/selection bundle for the N-to-2^N decoder
//
// Purpose: groups the decoder's select request (d_in/e/mode/in_valid/in_ready)
// and its registered selection outputs (d_out/out_valid/idx_out/wrap).
// Ports (signals):
//   d_in      N_IN   select index / scan start index
//   e         1      enable level
//   mode      1      0 = decode, 1 = scan
//   in_valid  1      request valid
//   in_ready  1      decoder can accept
//   d_out     OUT_W  one-hot selection
//   out_valid 1      d_out holds a valid selection
//   idx_out   N_IN   index of the active d_out bit
//   wrap      1      scan wrapped to index 0 this cycle
// Modports: master drives requests, slave is the decoder.
interface dec_nto2n_seq_if #(
  parameter int N_IN = 3
);
  localparam int OUT_W = 2 ** N_IN;

  logic [N_IN-1:0]  d_in;
  logic             e;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] d_out;
  logic             out_valid;
  logic [N_IN-1:0]  idx_out;
  logic             wrap;

  modport master (
    output d_in, e, mode, in_valid,
    input  in_ready, d_out, out_valid, idx_out, wrap
  );

  modport slave (
    input  d_in, e, mode, in_valid,
    output in_ready, d_out, out_valid, idx_out, wrap
  );
endinterface

// File: rtl/dec_nto2n_seq.sv
// rtl/dec_nto2n_seq.sv - registered N-to-2^N one-hot decoder with auto-scan
//
// Purpose: decodes an accepted index into a registered one-hot output, or
// walks the one-hot output from a start index, holding each position for
// HOLD_CYCLES clocks and wrapping from the top index back to 0.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous reset, active-high
//   bus  slave modport of dec_nto2n_seq_if (request in, selection out)
module dec_nto2n_seq #(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  dec_nto2n_seq_if.slave       bus
);
  localparam int OUT_W = 2 ** N_IN;
  localparam int HW    = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEC,
    S_SCAN
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] sel_q, sel_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             accept;

  assign bus.in_ready = (state_q != S_SCAN);
  assign accept       = bus.in_valid & bus.in_ready & bus.e;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    hold_d  = hold_q;

    if (!bus.e) begin
      // idx_out deliberately keeps its last value while disabled
      state_d = S_IDLE;
      sel_d   = '0;
      valid_d = 1'b0;
      hold_d  = '0;
    end else if (accept) begin
      sel_d   = OUT_W'(1) << bus.d_in;
      idx_d   = bus.d_in;
      valid_d = 1'b1;
      hold_d  = '0;
      state_d = bus.mode ? S_SCAN : S_DEC;
    end else if (state_q == S_SCAN) begin
      if (hold_q == HOLD_LAST) begin
        // Advance: rotating the one-hot keeps it aligned with idx + 1 and
        // wraps the top bit back to bit 0 without decoding idx again.
        hold_d = '0;
        idx_d  = idx_q + N_IN'(1);
        sel_d  = {sel_q[OUT_W-2:0], sel_q[OUT_W-1]};
        wrap_d = &idx_q;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  assign bus.d_out     = (ACTIVE_LOW != 0) ? ~sel_q : sel_q;
  assign bus.out_valid = valid_q;
  assign bus.idx_out   = idx_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_dec_nto2n_seq.sv
// tb/tb_dec_nto2n_seq.sv - self-checking bench for dec_nto2n_seq
module tb_dec_nto2n_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  dec_nto2n_seq_if #(.N_IN(3)) bus_a ();
  dec_nto2n_seq_if #(.N_IN(4)) bus_b ();

  dec_nto2n_seq #(.N_IN(3), .HOLD_CYCLES(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  dec_nto2n_seq #(.N_IN(4), .HOLD_CYCLES(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  int hold_of [2] = '{4, 1};
  int nb_of   [2] = '{3, 4};
  int al_of   [2] = '{0, 1};

  // Reference: 0 idle, 1 decode, 2 scan; scan position derived from the
  // start index and elapsed clocks since the scan was accepted.
  int m_st [2];
  int m_idx[2];
  int m_val[2];
  int m_wrap[2];
  int m_start[2];
  int m_el[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input int k, input bit r, input bit en, input bit v,
                       input bit md, input int din);
    if (r) begin
      m_st[k] = 0; m_idx[k] = 0; m_val[k] = 0; m_wrap[k] = 0;
    end else if (!en) begin
      m_st[k] = 0; m_val[k] = 0; m_wrap[k] = 0;
    end else if (m_st[k] != 2 && v) begin
      m_idx[k] = din; m_val[k] = 1; m_wrap[k] = 0;
      m_st[k] = md ? 2 : 1; m_start[k] = din; m_el[k] = 0;
    end else if (m_st[k] == 2) begin
      m_el[k]++;
      m_idx[k]  = (m_start[k] + m_el[k] / hold_of[k]) % (1 << nb_of[k]);
      m_wrap[k] = ((m_el[k] % hold_of[k]) == 0 && m_idx[k] == 0) ? 1 : 0;
    end else begin
      m_wrap[k] = 0;
    end
  endtask

  function automatic logic [31:0] exp_out(input int k);
    logic [31:0] x;
    int w;
    w = 1 << nb_of[k];
    x = m_val[k] != 0 ? (32'd1 << m_idx[k]) : 32'd0;
    if (al_of[k] != 0) x = ~x & ((32'd1 << w) - 32'd1);
    return x;
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    model(0, rst_a, bus_a.e, bus_a.in_valid, bus_a.mode, int'(bus_a.d_in));
    model(1, rst_b, bus_b.e, bus_b.in_valid, bus_b.mode, int'(bus_b.d_in));
    #1;
    chk({tag, " a.d_out"},     32'(bus_a.d_out),     exp_out(0));
    chk({tag, " a.out_valid"}, 32'(bus_a.out_valid), 32'(m_val[0]));
    chk({tag, " a.idx_out"},   32'(bus_a.idx_out),   32'(m_idx[0]));
    chk({tag, " a.wrap"},      32'(bus_a.wrap),      32'(m_wrap[0]));
    chk({tag, " a.in_ready"},  32'(bus_a.in_ready),  32'(m_st[0] != 2));
    chk({tag, " b.d_out"},     32'(bus_b.d_out),     exp_out(1));
    chk({tag, " b.out_valid"}, 32'(bus_b.out_valid), 32'(m_val[1]));
    chk({tag, " b.idx_out"},   32'(bus_b.idx_out),   32'(m_idx[1]));
    chk({tag, " b.wrap"},      32'(bus_b.wrap),      32'(m_wrap[1]));
    chk({tag, " b.in_ready"},  32'(bus_b.in_ready),  32'(m_st[1] != 2));
  endtask

  initial begin
    logic [7:0] onehot;
    logic [7:0] scan_exp;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_val[k] = 0; m_wrap[k] = 0;
      m_start[k] = 0; m_el[k] = 0;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.e = 1'b1; bus_a.in_valid = 1'b0; bus_a.mode = 1'b0; bus_a.d_in = '0;
    bus_b.e = 1'b1; bus_b.in_valid = 1'b0; bus_b.mode = 1'b0; bus_b.d_in = '0;

    // Reset
    step("reset");
    step("reset");
    chk("reset d_out",    32'(bus_a.d_out),     32'h00);
    chk("reset valid",    32'(bus_a.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus_a.in_ready),  32'd1);
    chk("reset_b d_out",  32'(bus_b.d_out),     32'hFFFF);
    rst_a = 1'b0; rst_b = 1'b0;

    // Decode sweep
    bus_a.mode = 1'b0; bus_a.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_a.d_in = 3'(i);
      step("sweep");
      onehot = 8'h01 << i;
      chk("sweep d_out", 32'(bus_a.d_out), 32'(onehot));
      chk("sweep idx",   32'(bus_a.idx_out), 32'(i));
    end

    // Disable
    bus_a.d_in = 3'd5;
    step("dis_acc");
    chk("dis d_out 20", 32'(bus_a.d_out), 32'h20);
    bus_a.e = 1'b0; bus_a.in_valid = 1'b0;
    step("dis_off");
    chk("dis d_out 00", 32'(bus_a.d_out), 32'h00);
    bus_a.in_valid = 1'b1; bus_a.d_in = 3'd6;
    step("dis_req");
    chk("dis hold d_out", 32'(bus_a.d_out), 32'h00);
    chk("dis keep idx",   32'(bus_a.idx_out), 32'd5);

    // Scan wrap
    bus_a.e = 1'b1; bus_a.d_in = 3'd6; bus_a.mode = 1'b1; bus_a.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step("scan");
      scan_exp = (c < 4) ? 8'h40 : (c < 8) ? 8'h80 : 8'h01;
      chk("scan d_out",    32'(bus_a.d_out),    32'(scan_exp));
      chk("scan wrap",     32'(bus_a.wrap),     32'(c == 8));
      chk("scan in_ready", 32'(bus_a.in_ready), 32'd0);
    end
    bus_a.e = 1'b0; bus_a.in_valid = 1'b0;
    step("scan_off");
    chk("scan_off in_ready", 32'(bus_a.in_ready), 32'd1);

    // Reset mid-scan
    bus_a.e = 1'b1; bus_a.d_in = 3'd6; bus_a.mode = 1'b1; bus_a.in_valid = 1'b1;
    step("rscan");
    bus_a.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step("rscan");
    chk("rscan at 80", 32'(bus_a.d_out), 32'h80);
    rst_a = 1'b1;
    step("rscan_rst");
    chk("rscan d_out", 32'(bus_a.d_out),   32'h00);
    chk("rscan idx",   32'(bus_a.idx_out), 32'd0);
    rst_a = 1'b0;
    bus_a.d_in = 3'd2; bus_a.mode = 1'b0; bus_a.in_valid = 1'b1;
    step("rscan_dec");
    chk("rscan dec 04", 32'(bus_a.d_out), 32'h04);
    bus_a.in_valid = 1'b0;

    // Active-low, 4-bit select
    bus_b.e = 1'b1; bus_b.d_in = 4'd9; bus_b.mode = 1'b0; bus_b.in_valid = 1'b1;
    step("al");
    chk("al d_out", 32'(bus_b.d_out),   32'hFDFF);
    chk("al idx",   32'(bus_b.idx_out), 32'd9);
    bus_b.in_valid = 1'b0;

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rst_a          = ($urandom_range(0, 63) == 0);
      bus_a.e        = ($urandom_range(0, 39) != 0);
      bus_a.in_valid = 1'($urandom_range(0, 1));
      bus_a.mode     = ($urandom_range(0, 3) == 0);
      bus_a.d_in     = 3'($urandom);
      rst_b          = ($urandom_range(0, 63) == 0);
      bus_b.e        = ($urandom_range(0, 39) != 0);
      bus_b.in_valid = 1'($urandom_range(0, 1));
      bus_b.mode     = ($urandom_range(0, 3) == 0);
      bus_b.d_in     = 4'($urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
